// File: rtl/mskaes_req_arbiter.sv
// mskaes_req_arbiter: two-requester scheduler in front of the masked AES-128 core; tags each issue, routes results back.
// Latency: accept/grant is combinational (0 cycles); rspN_valid rises the cycle after the core result pulse.
// Backpressure: a requester holding an unconsumed result cannot re-issue; core_ready low stalls every grant.
//
// Ports:
//   clk, nrst                         clock, asynchronous active-low reset
//   reqN_valid/ready/plaintext/key    requester N job input (N = 0, 1), shares 128*d bits
//   core_valid_in/ready/plaintext/key issue side toward the core
//   core_cipher_valid/ciphertext      single-cycle result pulse from the core
//   rspN_valid/ready/ciphertext       per-requester result buffer with valid/ready
//   err_orphan                        sticky: a result arrived with no outstanding tag
// Build option: define MSKAES_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

// Small generic FIFO. DEPTH must be a power of two so the pointers wrap naturally.
// Latency: data visible at out_dat the cycle after push. Backpressure: in_rdy low when full.
module mskaes_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push, pop;

    assign in_rdy  = (cnt_q != (AW+1)'(DEPTH));
    assign out_vld = (cnt_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module mskaes_req_arbiter #(
    parameter  int d = 2,
    localparam int W = 128 * d
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_plaintext,
    input  logic [W-1:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_plaintext,
    input  logic [W-1:0] req1_key,
    output logic         core_valid_in,
    input  logic         core_ready,
    output logic [W-1:0] core_plaintext,
    output logic [W-1:0] core_key,
    input  logic         core_cipher_valid,
    input  logic [W-1:0] core_ciphertext,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_ciphertext,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_ciphertext,
    output logic         err_orphan
);
    logic [1:0]   busy_q, busy_d;
    logic [1:0]   rsp_vld_q, rsp_vld_d;
    logic [W-1:0] rsp_dat_q [2];
    logic [W-1:0] rsp_dat_d [2];
    logic         err_q, err_d;

    logic [1:0]   req_vld, rsp_rdy, elig, grant, hs;
    logic         tag_in_rdy, tag_out_vld, tag_out_dat, tag_pop;

    assign req_vld = {req1_valid, req0_valid};
    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    // nrst in the eligibility term keeps the request side silent while reset is held,
    // since the ready path is otherwise purely combinational. Tag FIFO space is always
    // available when a requester is idle (one tag per busy requester), so that term never stalls.
    assign elig = req_vld & ~busy_q & {2{core_ready & tag_in_rdy & nrst}};

`ifdef MSKAES_ARB_RR_EN
    logic prio_q, prio_d;

    always_comb begin
        grant = elig;
        if (&elig) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
        // Preference moves to whoever lost; unchanged when nothing is granted.
        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        grant = elig;
        if (elig[0]) begin
            grant[1] = 1'b0;
        end
    end
`endif

    assign req0_ready     = grant[0];
    assign req1_ready     = grant[1];
    assign core_valid_in  = |grant;
    // AND-OR select per share; zero shares when idle, shares never recombined.
    assign core_plaintext = ({W{grant[0]}} & req0_plaintext) | ({W{grant[1]}} & req1_plaintext);
    assign core_key       = ({W{grant[0]}} & req0_key)       | ({W{grant[1]}} & req1_key);

    // Tag FIFO: the core completes in issue order, so the head names each result's owner.
    mskaes_fifo #(.WIDTH(1), .DEPTH(2)) u_tag_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .in_vld  (|grant),
        .in_rdy  (tag_in_rdy),
        .in_dat  (grant[1]),
        .out_vld (tag_out_vld),
        .out_rdy (core_cipher_valid),
        .out_dat (tag_out_dat)
    );

    assign tag_pop = core_cipher_valid & tag_out_vld;
    assign hs      = rsp_vld_q & rsp_rdy;

    always_comb begin
        busy_d    = busy_q;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        err_d     = err_q;
        for (int n = 0; n < 2; n++) begin
            if (hs[n]) begin
                rsp_vld_d[n] = 1'b0;
                busy_d[n]    = 1'b0;
                rsp_dat_d[n] = '0;
            end
        end
        // The owning buffer is never valid here: busy blocks re-issue until its handshake.
        if (tag_pop) begin
            rsp_vld_d[tag_out_dat] = 1'b1;
            rsp_dat_d[tag_out_dat] = core_ciphertext;
        end
        if (core_cipher_valid && !tag_out_vld) begin
            err_d = 1'b1;
        end
        busy_d = busy_d | grant;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q       <= '0;
            rsp_vld_q    <= '0;
            rsp_dat_q[0] <= '0;
            rsp_dat_q[1] <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            err_q     <= err_d;
        end
    end

    assign rsp0_valid      = rsp_vld_q[0];
    assign rsp1_valid      = rsp_vld_q[1];
    assign rsp0_ciphertext = rsp_dat_q[0];
    assign rsp1_ciphertext = rsp_dat_q[1];
    assign err_orphan      = err_q;
endmodule

// File: tb/tb_mskaes_req_arbiter.sv
`timescale 1ns/1ps
module tb_mskaes_req_arbiter;
    localparam int D   = 2;
    localparam int W   = 128 * D;
    localparam int LAT = 11;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         nrst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_rdy;
    logic [W-1:0] req_pt [2];
    logic [W-1:0] req_key [2];
    logic         core_valid_in;
    logic         core_ready = 1'b0;
    logic [W-1:0] core_plaintext, core_key;
    logic         core_cipher_valid = 1'b0;
    logic [W-1:0] core_ciphertext = '0;
    logic [1:0]   rsp_vld;
    logic [1:0]   rsp_ready = '0;
    logic [W-1:0] rsp_ct [2];
    logic         err_orphan;

    always #5 if (clk_en) clk = ~clk;

    mskaes_req_arbiter #(.d(D)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req0_valid        (req_valid[0]),
        .req0_ready        (req_rdy[0]),
        .req0_plaintext    (req_pt[0]),
        .req0_key          (req_key[0]),
        .req1_valid        (req_valid[1]),
        .req1_ready        (req_rdy[1]),
        .req1_plaintext    (req_pt[1]),
        .req1_key          (req_key[1]),
        .core_valid_in     (core_valid_in),
        .core_ready        (core_ready),
        .core_plaintext    (core_plaintext),
        .core_key          (core_key),
        .core_cipher_valid (core_cipher_valid),
        .core_ciphertext   (core_ciphertext),
        .rsp0_valid        (rsp_vld[0]),
        .rsp0_ready        (rsp_ready[0]),
        .rsp0_ciphertext   (rsp_ct[0]),
        .rsp1_valid        (rsp_vld[1]),
        .rsp1_ready        (rsp_ready[1]),
        .rsp1_ciphertext   (rsp_ct[1]),
        .err_orphan        (err_orphan)
    );

    // ---------------- reference model state ----------------
    typedef struct { int idx; logic [127:0] ct; } tag_t;
    typedef struct { int due; logic [127:0] ct; } cjob_t;
    typedef struct { logic v0; logic v1; logic cr; logic r0; logic r1; int sel; } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [1:0]   m_busy = '0;
    logic [1:0]   m_rvld = '0;
    logic [127:0] m_rdat [2];
    logic         m_err = 1'b0;
`ifdef MSKAES_ARB_RR_EN
    int           m_prio = 0;
`endif
    tag_t         mq[$];
    cjob_t        cq[$];
    int           dut_gi;
    int           g1_while_free;
    int           glog[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] xr(input logic [W-1:0] s);
        return s[127:0] ^ s[W-1:128];
    endfunction

    // Stand-in for the core's cipher: exact on the FIPS-197 vector, a keyed mix elsewhere.
    function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic new_job(input int n);
        req_pt[n]  = rnd256();
        req_key[n] = rnd256();
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_rvld = '0;
        m_rdat[0] = '0;
        m_rdat[1] = '0;
        m_err = 1'b0;
        mq.delete();
        cq.delete();
`ifdef MSKAES_ARB_RR_EN
        m_prio = 0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"}, req_rdy[0], 0);
        check({tag, "_req1_ready"}, req_rdy[1], 0);
        check({tag, "_core_valid_in"}, core_valid_in, 0);
        check({tag, "_core_pt"}, core_plaintext, 0);
        check({tag, "_core_key"}, core_key, 0);
        check({tag, "_rsp0_valid"}, rsp_vld[0], 0);
        check({tag, "_rsp1_valid"}, rsp_vld[1], 0);
        check({tag, "_rsp0_ct"}, rsp_ct[0], 0);
        check({tag, "_rsp1_ct"}, rsp_ct[1], 0);
        check({tag, "_err_orphan"}, err_orphan, 0);
    endtask

    // One clock cycle: called at posedge+1 with inputs applied, returns at the next posedge+1.
    task automatic step();
        logic e0, e1, g0, g1;
        int gi;
        tag_t t;
        cjob_t cj;
        logic [W-1:0] exp_pt, exp_key;
        logic [127:0] mask;
        #1;
        e0 = req_valid[0] & ~m_busy[0] & core_ready;
        e1 = req_valid[1] & ~m_busy[1] & core_ready;
`ifdef MSKAES_ARB_RR_EN
        if (e0 && e1) begin
            g0 = (m_prio == 0);
            g1 = ~g0;
        end else begin
            g0 = e0;
            g1 = e1;
        end
`else
        g0 = e0;
        g1 = e1 & ~e0;
`endif
        gi = g0 ? 0 : (g1 ? 1 : -1);
        exp_pt  = (gi == 0) ? req_pt[0]  : (gi == 1) ? req_pt[1]  : '0;
        exp_key = (gi == 0) ? req_key[0] : (gi == 1) ? req_key[1] : '0;
        check("req0_ready", req_rdy[0], g0);
        check("req1_ready", req_rdy[1], g1);
        check("core_valid_in", core_valid_in, g0 | g1);
        check("core_plaintext", core_plaintext, exp_pt);
        check("core_key", core_key, exp_key);
        for (int n = 0; n < 2; n++) begin
            check($sformatf("rsp%0d_valid", n), rsp_vld[n], m_rvld[n]);
            if (m_rvld[n]) check($sformatf("rsp%0d_ct_xor", n), xr(rsp_ct[n]), m_rdat[n]);
            else           check($sformatf("rsp%0d_ct_zero", n), rsp_ct[n], 0);
        end
        check("err_orphan", err_orphan, m_err);

        dut_gi = req_rdy[0] ? 0 : (req_rdy[1] ? 1 : -1);
        if (req_rdy[1] && req_valid[0] && !m_busy[0]) g1_while_free++;

        // core environment: accept whatever is presented
        if (core_valid_in && core_ready) begin
            cj.due = cyc + LAT;
            cj.ct  = enc(xr(core_plaintext), xr(core_key));
            cq.push_back(cj);
        end

        // model update: handshakes, result routing, issue
        for (int n = 0; n < 2; n++) begin
            if (m_rvld[n] && rsp_ready[n]) begin
                m_rvld[n] = 1'b0;
                m_busy[n] = 1'b0;
            end
        end
        if (core_cipher_valid) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                t = mq.pop_front();
                m_rvld[t.idx] = 1'b1;
                m_rdat[t.idx] = t.ct;
            end
        end
        if (gi >= 0) begin
            t.idx = gi;
            t.ct  = enc(xr(req_pt[gi]), xr(req_key[gi]));
            mq.push_back(t);
            m_busy[gi] = 1'b1;
`ifdef MSKAES_ARB_RR_EN
            m_prio = 1 - gi;
`endif
        end

        @(posedge clk);
        cyc++;
        #1;
        if (cq.size() > 0 && cq[0].due == cyc) begin
            cj = cq.pop_front();
            mask = rnd256();
            core_cipher_valid = 1'b1;
            core_ciphertext   = {mask, cj.ct ^ mask};
        end else begin
            core_cipher_valid = 1'b0;
            core_ciphertext   = rnd256();
        end
    endtask

    task automatic drain();
        req_valid  = '0;
        rsp_ready  = 2'b11;
        core_ready = 1'b1;
        repeat (LAT + 6) step();
    endtask

    task automatic fips_job(input string tag);
        int k;
        req_pt[0]  = {128'h0, FIPS_PT};
        req_key[0] = {128'h0, FIPS_KEY};
        req_valid  = 2'b01;
        core_ready = 1'b1;
        rsp_ready  = 2'b00;
        step();
        check({tag, "_accept_now"}, (dut_gi == 0), 1);
        req_valid = '0;
        k = 0;
        while (!rsp_vld[0] && k < 40) begin
            step();
            k++;
        end
        check({tag, "_rsp_in_time"}, (k < 40), 1);
        check({tag, "_ct"}, xr(rsp_ct[0]), FIPS_CT);
        repeat (5) step();
        check({tag, "_hold_valid"}, rsp_vld[0], 1);
        check({tag, "_hold_ct"}, xr(rsp_ct[0]), FIPS_CT);
        rsp_ready = 2'b01;
        step();
        check({tag, "_cleared"}, rsp_vld[0], 0);
        check({tag, "_ct_zero"}, rsp_ct[0], 0);
    endtask

    vec_t tbl [7];

    initial begin
        int breaks, c0, c1, r1_late, r0_done;

        tbl[0] = '{v0:1'b0, v1:1'b0, cr:1'b1, r0:1'b0, r1:1'b0, sel:-1};
        tbl[1] = '{v0:1'b1, v1:1'b0, cr:1'b1, r0:1'b1, r1:1'b0, sel:0};
        tbl[2] = '{v0:1'b0, v1:1'b1, cr:1'b1, r0:1'b0, r1:1'b1, sel:1};
        tbl[3] = '{v0:1'b1, v1:1'b1, cr:1'b1, r0:1'b1, r1:1'b0, sel:0};
        tbl[4] = '{v0:1'b1, v1:1'b1, cr:1'b0, r0:1'b0, r1:1'b0, sel:-1};
        tbl[5] = '{v0:1'b1, v1:1'b0, cr:1'b0, r0:1'b0, r1:1'b0, sel:-1};
        tbl[6] = '{v0:1'b0, v1:1'b1, cr:1'b0, r0:1'b0, r1:1'b0, sel:-1};

        model_reset();
        new_job(0);
        new_job(1);

        // reset values, with requests pending to show ready stays low
        req_valid  = 2'b11;
        core_ready = 1'b1;
        #1 nrst = 1'b0;
        #1 check_all_zero("reset");
        nrst = 1'b1;

        // grant decode from idle state, clock held still
        for (int i = 0; i < 7; i++) begin
            req_valid  = {tbl[i].v1, tbl[i].v0};
            core_ready = tbl[i].cr;
            #1;
            check($sformatf("tbl%0d_req0_ready", i), req_rdy[0], tbl[i].r0);
            check($sformatf("tbl%0d_req1_ready", i), req_rdy[1], tbl[i].r1);
            check($sformatf("tbl%0d_core_valid", i), core_valid_in, tbl[i].r0 | tbl[i].r1);
            check($sformatf("tbl%0d_core_pt", i), core_plaintext,
                  (tbl[i].sel == 0) ? req_pt[0] : (tbl[i].sel == 1) ? req_pt[1] : '0);
            check($sformatf("tbl%0d_core_key", i), core_key,
                  (tbl[i].sel == 0) ? req_key[0] : (tbl[i].sel == 1) ? req_key[1] : '0);
        end
        req_valid  = '0;
        core_ready = 1'b0;
        clk_en = 1'b1;
        @(posedge clk);
        #1;

        fips_job("fips1");
        drain();

        // both requesters saturating, responses always consumed
        new_job(0);
        new_job(1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        core_ready = 1'b1;
        glog.delete();
        g1_while_free = 0;
        repeat (60) begin
            step();
            if (dut_gi >= 0) begin
                glog.push_back(dut_gi);
                new_job(dut_gi);
            end
        end
        breaks = 0;
        c0 = 0;
        c1 = 0;
        foreach (glog[i]) begin
            if (glog[i] == 0) c0++; else c1++;
            if (i > 0 && glog[i] == glog[i-1]) breaks++;
        end
        check("sat_req0_grants", (c0 > 2), 1);
        check("sat_req1_grants", (c1 > 2), 1);
`ifdef MSKAES_ARB_RR_EN
        check("rr_alternation_breaks", breaks, 0);
`else
        check("fixed_req1_while_req0_free", g1_while_free, 0);
`endif
        check("sat_no_orphan", err_orphan, 0);
        drain();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req_valid  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            rsp_ready  = {($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0)};
            core_ready = ($urandom_range(0, 4) != 0);
            step();
            if (dut_gi >= 0) new_job(dut_gi);
        end
        drain();

        // rsp1 withheld for 50 cycles
        new_job(0);
        new_job(1);
        req_valid = 2'b11;
        rsp_ready = 2'b01;
        core_ready = 1'b1;
        r1_late = 0;
        r0_done = 0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_vld[0]) r0_done++;
            step();
            if (i >= 2 && req_rdy[1]) r1_late++;
            if (dut_gi >= 0) new_job(dut_gi);
        end
        check("hold_req1_never_ready", r1_late, 0);
        check("hold_req0_progress", (r0_done >= 2), 1);
        check("hold_rsp1_valid", rsp_vld[1], 1);
        drain();

        // orphan result
        core_cipher_valid = 1'b1;
        core_ciphertext = rnd256();
        step();
        repeat (3) step();
        check("orphan_err", err_orphan, 1);
        check("orphan_rsp0_valid", rsp_vld[0], 0);
        check("orphan_rsp1_valid", rsp_vld[1], 0);
        repeat (3) step();
        check("orphan_sticky", err_orphan, 1);

        // asynchronous reset with two jobs in flight
        new_job(0);
        new_job(1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        core_ready = 1'b1;
        repeat (2) begin
            step();
            if (dut_gi >= 0) new_job(dut_gi);
        end
        #2 nrst = 1'b0;
        #1 check_all_zero("arst");
        model_reset();
        core_cipher_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        nrst = 1'b1;
        step();
        fips_job("fips2");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mskaes_req_arbiter.md
# mskaes_req_arbiter

Two-requester arbiter and scheduler in front of the masked round-based AES-128 core. It grants one requester per core acceptance slot and forwards its shared plaintext/key to the core. Each issue is tagged with the requester index, and the core's single-cycle ciphertext pulse is routed back into a per-requester output buffer with valid/ready backpressure. It sits between the system-side masked request/response interfaces and the core's `valid_in`/`ready`/`cipher_valid` handshake.

## Interface
- `d`, 2: number of shares. All data buses are 128·d bits in the share layout of the core.
- `clk` in 1: single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N = 0, 1): requester N holds a job.
- `reqN_ready` out 1: job N accepted this cycle.
- `reqN_plaintext` in 128·d: shared plaintext.
- `reqN_key` in 128·d: shared key.
- `core_valid_in` out 1: to core `valid_in`.
- `core_ready` in 1: from core `ready`.
- `core_plaintext` out 128·d: to core `sh_plaintext`.
- `core_key` out 128·d: to core `sh_key`.
- `core_cipher_valid` in 1: from core `cipher_valid` (1-cycle pulse).
- `core_ciphertext` in 128·d: from core `sh_ciphertext`.
- `rspN_valid` out 1: ciphertext for requester N is held.
- `rspN_ready` in 1: requester N takes the result.
- `rspN_ciphertext` out 128·d: shared ciphertext.
- `err_orphan` out 1: sticky. Set when a core result arrives with no outstanding tag.

## Operation
- `busyN` flag per requester. It is set on issue and cleared on the `rspN` handshake. There is at most one outstanding job per requester, so at most 2 jobs are in the core.
- Eligibility: `eligN = reqN_valid & ~busyN & core_ready`.
- Grant: one-hot among eligible requesters, chosen by the priority pointer `prio`. `prio` names the preferred requester.
- `reqN_ready = grantN`. `core_valid_in = grant0 | grant1`. Both are combinational in the same cycle.
- `core_plaintext`/`core_key` are the AND-gated selection of the granted requester's shares. They are all-zero shares when there is no grant. No share recombination.
- On issue (posedge with a grant):
  - push the requester index into a 2-entry in-order tag FIFO;
  - set `busyN`;
  - update `prio` (see Configuration).
- The core finishes jobs in issue order (identical latency per job), so the FIFO head identifies each result.
- On `core_cipher_valid`:
  - pop the head tag T;
  - register `core_ciphertext` into buffer T;
  - set `rspT_valid`.
- If the FIFO is empty on `core_cipher_valid`: drop the result, leave the buffers unchanged, set `err_orphan`.
- On the `rspN` handshake (`rspN_valid & rspN_ready`):
  - clear `rspN_valid` and `busyN`;
  - clear buffer N to zero shares, so no stale shares remain on the bus.
- Buffer N cannot already be valid at capture, because `busyN` blocks re-issue until the handshake. Buffer overwrite is structurally impossible.

## Timing
- Reset values: `reqN_ready`=0, `core_valid_in`=0, `core_plaintext`/`core_key`=0, `rspN_valid`=0, `rspN_ciphertext`=0, `err_orphan`=0, `busyN`=0, FIFO empty, `prio`=0.
- Accept latency: 0 cycles. Ready is combinational from `reqN_valid` and `core_ready`.
- Response latency: `rspN_valid` rises on the cycle after the `core_cipher_valid` pulse.
- `rspN_valid` and `rspN_ciphertext` remain stable until `rspN_ready`.
- A handshake and a new `reqN_valid` in the same cycle cause no grant for N in that cycle, because `busyN` is cleared only at the edge. This gives a 1-cycle bubble.
- An issue and a `core_cipher_valid` in the same cycle: FIFO push and pop occur together, and the count is unchanged.
- `core_ready` low: no grant, and `prio` is unchanged.
- Reset mid-operation: all state clears asynchronously. The core must be reset in the same window. Any later `core_cipher_valid` is handled as an orphan.

## Configuration
- `MSKAES_ARB_RR_EN` defined: round-robin arbitration. After each grant, `prio` ← index of the non-granted requester.
- `MSKAES_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins, and `prio` is constant 0.

## Test plan
- Single job, FIPS-197 vector. Stimulus on req0: key shares {000102…0f, 0}, plaintext shares {00112233…ff, 0}. Required: `req0_ready` asserts at once, and after the core pulse `rsp0` share XOR = 69c4e0d86a7b0430d8cdb78070b4c55a; `rsp0_valid` holds until `rsp0_ready`.
- Both requesters valid every cycle, RR enabled → grants alternate 0, 1, 0, 1. Each response goes to the correct requester, and `err_orphan` stays 0.
- Same traffic with RR disabled, `rsp0_ready` always 1 → requester 0 is granted each time it is not busy. Requester 1 is granted only while req0 is busy.
- `rsp1_ready` held low for 50 cycles → `req1_ready` stays 0 throughout. req0 continues to complete, and `rsp1_ciphertext` is unchanged.
- Inject `core_cipher_valid` with no issue → result dropped, `err_orphan`=1 until reset, and `rspN_valid` stays 0.
- Assert `nrst`=0 asynchronously with 2 jobs in flight → all outputs are 0 immediately. After release, a new FIPS-197 job completes correctly.
